// File: rtl/auv_csr_machinfo.sv
// Read-only machine-information CSR block (mvendorid..mconfigptr) on the core CSR bus.
// Latency: ACK_LAT cycles from the accepting edge to a one-cycle registered ack.
// Backpressure: none; one transaction in flight, new requests ignored until back in IDLE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_cbus_sel          block selected by the CSR bus decoder
//   i_cbus_addr[11:0]   CSR address
//   i_cbus_rd/i_cbus_wr read / write request
//   i_cbus_dat_wr[31:0] write data (ignored: every register here is read-only)
//   o_cbus_dat_rd[31:0] read data, meaningful only while o_cbus_ack=1
//   o_cbus_ack          single-cycle transaction-complete pulse
//   o_cbus_err          illegal access (write or unmapped), meaningful only with ack
module auv_csr_machinfo #(
    parameter logic [31:0] VENDOR_ID  = 32'h0000_0000,
    parameter logic [31:0] ARCH_ID    = 32'h0000_0000,
    parameter logic [31:0] IMP_ID     = 32'h0000_0001,
    parameter logic [31:0] HART_ID    = 32'h0000_0000,
    parameter logic [31:0] CONFIG_PTR = 32'h0000_0000,
    parameter int          ACK_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cbus_sel,
    input  logic [11:0] i_cbus_addr,
    input  logic        i_cbus_rd,
    input  logic        i_cbus_wr,
    input  logic [31:0] i_cbus_dat_wr,
    output logic [31:0] o_cbus_dat_rd,
    output logic        o_cbus_ack,
    output logic        o_cbus_err
);

    if (ACK_LAT < 1 || ACK_LAT > 15) begin : g_bad_ack_lat
        $error("auv_csr_machinfo: ACK_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT_M1 = 4'(ACK_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [11:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic        w_req;
    logic        w_latch;
    logic [11:0] w_src_addr;
    logic        w_src_rd;
    logic        w_src_wr;
    logic [31:0] w_dec_dat;
    logic        w_dec_err;
    logic        w_resp_nxt;
    logic        w_unused;

    // Write data has no destination; fold it so it is visibly consumed.
    assign w_unused = ^i_cbus_dat_wr;

    assign w_req = i_cbus_sel & (i_cbus_rd | i_cbus_wr);

    // Next-state logic. The decode source is the live bus only in IDLE
    // (needed when ACK_LAT==1 and the response is loaded on the accepting
    // edge); otherwise the latched request is used and the bus is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_src_addr  = r_addr;
        w_src_rd    = r_rd;
        w_src_wr    = r_wr;
        case (r_state)
            S_IDLE: begin
                w_src_addr = i_cbus_addr;
                w_src_rd   = i_cbus_rd;
                w_src_wr   = i_cbus_wr;
                if (w_req) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = (ACK_LAT == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = 4'(r_cnt - 4'd1);
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Any write (including rd&wr) or an unmapped address is an error with zero data.
    always_comb begin
        w_dec_err = 1'b1;
        w_dec_dat = 32'h0;
        if (w_src_rd && !w_src_wr) begin
            case (w_src_addr)
                12'hF11: begin w_dec_err = 1'b0; w_dec_dat = VENDOR_ID;  end
                12'hF12: begin w_dec_err = 1'b0; w_dec_dat = ARCH_ID;    end
                12'hF13: begin w_dec_err = 1'b0; w_dec_dat = IMP_ID;     end
                12'hF14: begin w_dec_err = 1'b0; w_dec_dat = HART_ID;    end
                12'hF15: begin w_dec_err = 1'b0; w_dec_dat = CONFIG_PTR; end
                default: begin w_dec_err = 1'b1; w_dec_dat = 32'h0;      end
            endcase
        end
    end

    assign w_resp_nxt = (w_state_nxt == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_addr        <= 12'h0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            o_cbus_ack    <= 1'b0;
            o_cbus_err    <= 1'b0;
            o_cbus_dat_rd <= 32'h0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            if (w_latch) begin
                r_addr <= i_cbus_addr;
                r_rd   <= i_cbus_rd;
                r_wr   <= i_cbus_wr;
            end
            // Outputs are loaded on the edge that enters RESP, so ack is high
            // exactly while the FSM sits in RESP.
            o_cbus_ack    <= w_resp_nxt;
            o_cbus_err    <= w_resp_nxt ? w_dec_err : 1'b0;
            o_cbus_dat_rd <= w_resp_nxt ? w_dec_dat : 32'h0;
        end
    end

endmodule

// File: tb/tb_auv_csr_machinfo.sv
module tb_auv_csr_machinfo;

    typedef struct {
        int          idx;
        int          cyc;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    localparam int LAT [3] = '{1, 4, 8};

    logic             clk;
    logic             rst_n;
    logic [2:0]       sel, rd, wr;
    logic [2:0][11:0] addr;
    logic [2:0][31:0] dwr;
    logic [2:0][31:0] dat_o;
    logic [2:0]       ack_o, err_o;
    logic [2:0]       prev_ack;

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t mon_e;

    auv_csr_machinfo #(.ACK_LAT(1), .HART_ID(32'h3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_cbus_sel(sel[0]), .i_cbus_addr(addr[0]),
        .i_cbus_rd(rd[0]), .i_cbus_wr(wr[0]), .i_cbus_dat_wr(dwr[0]),
        .o_cbus_dat_rd(dat_o[0]), .o_cbus_ack(ack_o[0]), .o_cbus_err(err_o[0]));

    auv_csr_machinfo #(.ACK_LAT(4), .IMP_ID(32'hA5A5_0001), .VENDOR_ID(32'h0000_0602),
                       .CONFIG_PTR(32'h0000_1000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_cbus_sel(sel[1]), .i_cbus_addr(addr[1]),
        .i_cbus_rd(rd[1]), .i_cbus_wr(wr[1]), .i_cbus_dat_wr(dwr[1]),
        .o_cbus_dat_rd(dat_o[1]), .o_cbus_ack(ack_o[1]), .o_cbus_err(err_o[1]));

    auv_csr_machinfo #(.ACK_LAT(8), .ARCH_ID(32'h0000_00C3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_cbus_sel(sel[2]), .i_cbus_addr(addr[2]),
        .i_cbus_rd(rd[2]), .i_cbus_wr(wr[2]), .i_cbus_dat_wr(dwr[2]),
        .o_cbus_dat_rd(dat_o[2]), .o_cbus_ack(ack_o[2]), .o_cbus_err(err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge, each DUT either presents an expected ack or idles at zero.
    initial prev_ack = 3'b000;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ack_o[i]) begin
                checks++;
                if (prev_ack[i]) begin
                    errors++;
                    $display("FAIL ack_width dut%0d: ack high on consecutive cycles at cyc %0d, want one-cycle pulse", i, cyc);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack dut%0d: ack at cyc %0d dat=%h err=%b, want no ack", i, cyc, dat_o[i], err_o[i]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.idx != i || mon_e.cyc != cyc || dat_o[i] !== mon_e.dat || err_o[i] !== mon_e.err)
                    begin
                        errors++;
                        $display("FAIL resp dut%0d: got cyc %0d dat=%h err=%b, want dut%0d cyc %0d dat=%h err=%b",
                                 i, cyc, dat_o[i], err_o[i], mon_e.idx, mon_e.cyc, mon_e.dat, mon_e.err);
                    end
                end
            end else begin
                checks++;
                if (dat_o[i] !== 32'h0 || err_o[i] !== 1'b0 || ack_o[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs dut%0d: cyc %0d ack=%b dat=%h err=%b, want all zero", i, cyc, ack_o[i], dat_o[i], err_o[i]);
                end
            end
            prev_ack[i] = ack_o[i];
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ack_timeout: %0d expected acks outstanding after 60 cycles, want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int d);
        sel[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
        addr[d] = 12'h0; dwr[d] = 32'h0;
    endtask

    // One request held for a single sampling edge, then released.
    task automatic txn(input int d, input logic [11:0] a, input logic r, input logic w,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee);
        @(posedge clk);
        #1;
        sel[d] = 1'b1; addr[d] = a; rd[d] = r; wr[d] = w; dwr[d] = wd;
        sb.push_back('{idx: d, cyc: cyc + LAT[d], dat: ed, err: ee});
        @(posedge clk);
        #1;
        drop(d);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sel = '0; rd = '0; wr = '0; addr = '0; dwr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ACK_LAT=1 instance
        txn(0, 12'hF14, 1'b1, 1'b0, 32'h0, 32'h0000_0003, 1'b0);
        txn(0, 12'hF13, 1'b1, 1'b0, 32'h0, 32'h0000_0001, 1'b0);
        txn(0, 12'hF11, 1'b1, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
        txn(0, 12'hF16, 1'b1, 1'b0, 32'h0, 32'h0000_0000, 1'b1);
        txn(0, 12'hF14, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 1'b1);

        // ACK_LAT=4 instance
        txn(1, 12'hF13, 1'b1, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0);
        txn(1, 12'hF11, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        txn(1, 12'hF11, 1'b1, 1'b0, 32'h0, 32'h0000_0602, 1'b0);
        txn(1, 12'hF15, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1);
        txn(1, 12'hF15, 1'b1, 1'b0, 32'h0, 32'h0000_1000, 1'b0);
        txn(1, 12'hF16, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        txn(1, 12'h300, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        txn(1, 12'hF10, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);

        // Request held continuously: accepted at e+1, e+6, e+11 (RESP then IDLE between).
        @(posedge clk);
        #1;
        base = cyc;
        sel[1] = 1'b1; addr[1] = 12'hF13; rd[1] = 1'b1;
        sb.push_back('{idx: 1, cyc: base + 4,  dat: 32'hA5A5_0001, err: 1'b0});
        sb.push_back('{idx: 1, cyc: base + 9,  dat: 32'hA5A5_0001, err: 1'b0});
        sb.push_back('{idx: 1, cyc: base + 14, dat: 32'hA5A5_0001, err: 1'b0});
        repeat (11) @(posedge clk);
        #1;
        drop(1);
        drain();

        // Not selected: no ack may appear for 20 cycles.
        sel[1] = 1'b0; rd[1] = 1'b1; addr[1] = 12'hF11;
        repeat (20) @(posedge clk);
        #1;
        drop(1);
        drain();

        // ACK_LAT=8: reset three cycles into WAIT drops the transaction.
        @(posedge clk);
        #1;
        sel[2] = 1'b1; addr[2] = 12'hF12; rd[2] = 1'b1;
        @(posedge clk);
        #1;
        drop(2);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        txn(2, 12'hF12, 1'b1, 1'b0, 32'h0, 32'h0000_00C3, 1'b0);
        txn(2, 12'hF14, 1'b1, 1'b0, 32'h0, 32'h0000_0000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/auv_csr_machinfo.md
Name: auv_csr_machinfo

Overview:
- Parametrised successor of the machine-information CSR stub.
- Implements the read-only machine information CSRs on the core's CSR bus:
  - mvendorid 0xF11
  - marchid 0xF12
  - mimpid 0xF13
  - mhartid 0xF14
  - mconfigptr 0xF15
- Adds address decode, configurable ack latency, and an error response for illegal accesses, which the core turns into an illegal-instruction trap.
- Sits beside the main CSR file, selected by the CSR bus decoder via cbus_sel.

Parameters:
- VENDOR_ID, 32'h0000_0000, value returned for mvendorid.
- ARCH_ID, 32'h0000_0000, value returned for marchid.
- IMP_ID, 32'h0000_0001, value returned for mimpid.
- HART_ID, 32'h0000_0000, value returned for mhartid.
- CONFIG_PTR, 32'h0000_0000, value returned for mconfigptr.
- ACK_LAT, 1, cycles from request acceptance to ack. Legal range 1..15; elaboration error outside this range.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cbus_sel  in  1  block selected by CSR bus decoder.
- cbus_addr  in  12  CSR address.
- cbus_rd  in  1  read request.
- cbus_wr  in  1  write request.
- cbus_dat_wr  in  32  write data; ignored, since all registers are read-only.
- cbus_dat_rd  out  32  read data, valid only while cbus_ack=1.
- cbus_ack  out  1  single-cycle transaction-complete pulse.
- cbus_err  out  1  illegal access; valid only while cbus_ack=1.

Behaviour:
- Reset (async, any state): state=IDLE, latency counter=0, cbus_ack=0, cbus_err=0, cbus_dat_rd=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is cbus_sel & (cbus_rd | cbus_wr) at a rising edge.
  - On a request, latch addr, rd and wr, and load counter = ACK_LAT-1.
  - Next state: RESP if ACK_LAT==1, otherwise WAIT.
- WAIT:
  - Counter decrements each cycle.
  - Enter RESP when counter==1 at the edge, so total latency is ACK_LAT cycles.
  - Bus inputs are ignored; the latched request is used. Dropping cbus_sel mid-transaction does not cancel it.
- RESP:
  - cbus_ack=1 for exactly one cycle, with cbus_dat_rd and cbus_err driven from the latched request.
  - Next state is IDLE unconditionally.
  - A request held during RESP is not accepted. The requester must drop rd/wr after ack, so there is a minimum of 1 idle cycle between transactions.
- Latency: request sampled at edge k gives cbus_ack high in the cycle after edge k+ACK_LAT-1. With ACK_LAT=1, ack is high in the cycle immediately after the request edge.
- Decode and response:
  - Mapped address with rd only: err=0, dat_rd = the corresponding parameter.
  - Any access with the latched wr=1 (including rd&wr): err=1, dat_rd=0. No state changes.
  - Unmapped address (anything other than 0xF11..0xF15): err=1, dat_rd=0.
- Outside RESP: cbus_dat_rd=0, cbus_err=0, cbus_ack=0. All outputs are registered; no combinational path from inputs to outputs.
- cbus_sel=0 with rd/wr=1 in IDLE: no action, no ack.
- Reset asserted in WAIT or RESP: the transaction is dropped, and no ack is issued after reset release.

Test Plan:
- ACK_LAT=1, HART_ID=3:
  - Read 0xF14 → ack high exactly 1 cycle, one cycle after the request edge; dat_rd=32'h3, err=0.
- ACK_LAT=4, IMP_ID=32'hA5A5_0001:
  - Read 0xF13 → ack in the 4th cycle after acceptance; dat_rd=32'hA5A5_0001.
  - ack held for 1 cycle only.
  - A request held continuously produces one ack per transaction, with at least one idle cycle between acks.
- Write 0xF11 with dat_wr=32'hFFFF_FFFF → ack with err=1, dat_rd=0; subsequent read of 0xF11 still returns VENDOR_ID.
- Read 0xF16 and read 0x300 → ack with err=1, dat_rd=0; cbus_sel=0 with cbus_rd=1 → no ack for 20 cycles.
- ACK_LAT=8:
  - Assert rst_n=0 three cycles into WAIT, then release → no ack ever issued; all outputs 0.
  - A fresh read of 0xF12 afterwards completes normally.
